// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : adder_share_arbiter
// Purpose : Round-robin sharing of one external combinational adder between
//           NREQ requesters, with a registered valid/ready result port.
// Revision: 1.0 - initial release
// ============================================================================
module adder_share_arbiter #(
    parameter int width = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*width-1:0]   req_A,
    input  logic [NREQ*width-1:0]   req_B,
    input  logic [NREQ-1:0]         req_Cin,
    output logic [NREQ-1:0]         gnt,
    output logic [width-1:0]        add_A,
    output logic [width-1:0]        add_B,
    output logic                    add_Cin,
    input  logic [width-1:0]        add_Sum,
    input  logic                    add_Cout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [width-1:0]        out_Sum,
    output logic                    out_Cout,
    output logic                    out_ovf,
    output logic [IDW-1:0]          out_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_id;
    logic [width-1:0]   r_opa;
    logic [width-1:0]   r_opb;
    logic               r_cin;

    logic [NREQ-1:0]    w_pick;
    logic [IDW-1:0]     w_pick_id;
    logic               w_found;
    int                 w_idx;

    // Scan requesters starting at the pointer, wrapping past NREQ-1 to 0.
    always_comb begin
        w_pick    = '0;
        w_pick_id = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = (int'(r_ptr) + i) % NREQ;
            if (!w_found && req[w_idx]) begin
                w_found        = 1'b1;
                w_pick[w_idx]  = 1'b1;
                w_pick_id      = IDW'(w_idx);
            end
        end
    end

    assign gnt     = (r_state == S_IDLE && !rst) ? w_pick : '0;
    assign add_A   = r_opa;
    assign add_B   = r_opb;
    assign add_Cin = r_cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_id      <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_cin     <= 1'b0;
            out_valid <= 1'b0;
            out_Sum   <= '0;
            out_Cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_opa   <= req_A[int'(w_pick_id)*width +: width];
                        r_opb   <= req_B[int'(w_pick_id)*width +: width];
                        r_cin   <= req_Cin[w_pick_id];
                        r_id    <= w_pick_id;
                        r_ptr   <= (w_pick_id == IDW'(NREQ-1)) ? '0 : w_pick_id + 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    out_Sum   <= add_Sum;
                    out_Cout  <= add_Cout;
                    out_id    <= r_id;
                    // Overflow: like-signed operands producing an opposite-signed sum.
                    out_ovf   <= (r_opa[width-1] == r_opb[width-1]) &&
                                 (add_Sum[width-1] != r_opa[width-1]);
                    out_valid <= 1'b1;
                    r_state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_adder_share_arbiter
// Purpose : Scenario bench for adder_share_arbiter with a reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adder_share_arbiter;

    localparam int c_w = 16;
    localparam int c_n = 4;

    logic              clk;
    logic              rst;
    logic [c_n-1:0]    req;
    logic [c_n*c_w-1:0] req_A;
    logic [c_n*c_w-1:0] req_B;
    logic [c_n-1:0]    req_Cin;
    logic [c_n-1:0]    gnt;
    logic [c_w-1:0]    add_A, add_B, add_Sum;
    logic              add_Cin, add_Cout;
    logic              out_valid, out_ready;
    logic [c_w-1:0]    out_Sum;
    logic              out_Cout, out_ovf;
    logic [1:0]        out_id;

    int checks = 0;
    int errors = 0;

    adder_share_arbiter #(.width(c_w), .NREQ(c_n), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_A(req_A), .req_B(req_B),
        .req_Cin(req_Cin), .gnt(gnt), .add_A(add_A), .add_B(add_B),
        .add_Cin(add_Cin), .add_Sum(add_Sum), .add_Cout(add_Cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_Sum(out_Sum),
        .out_Cout(out_Cout), .out_ovf(out_ovf), .out_id(out_id)
    );

    // The shared external adder.
    assign {add_Cout, add_Sum} = {1'b0, add_A} + {1'b0, add_B} + {{c_w{1'b0}}, add_Cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {ovf, cout, sum} from integer arithmetic.
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
        int   u, s;
        logic ov, co;
        u  = int'(a) + int'(b) + int'(c);
        s  = int'($signed(a)) + int'($signed(b)) + int'(c);
        ov = (s > 32767) || (s < -32768);
        co = (u > 65535);
        return {ov, co, u[15:0]};
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int ptr);
        for (int i = 0; i < c_n; i++)
            if (r[(ptr + i) % c_n]) return (ptr + i) % c_n;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic c);
        req_A[k*c_w +: c_w] = a;
        req_B[k*c_w +: c_w] = b;
        req_Cin[k]          = c;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; out_ready = 1'b0;
        req_A = '0; req_B = '0; req_Cin = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_op(3, 16'h7FFF, 16'h0001, 1'b0);
        req = 4'b1000;
        @(negedge clk);
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rst_pre_gnt got %b want 1000", gnt); end
        step(); req = 4'b0000;
        step(); req = 4'b1111;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd3) begin errors++;
            $display("FAIL rst_pre_hold got valid=%b id=%0d want valid=1 id=3", out_valid, out_id); end
        #2 rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b want 0000", gnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
        checks++; if (out_Sum !== 16'h0000 || out_Cout !== 1'b0 || out_ovf !== 1'b0 || out_id !== 2'd0) begin errors++;
            $display("FAIL rst_out got sum=%h cout=%b ovf=%b id=%0d want 0 0 0 0", out_Sum, out_Cout, out_ovf, out_id); end
        step(); rst = 1'b0; req = '0;
    endtask

    task automatic test_single_carry();
        do_reset();
        set_op(2, 16'hFFFF, 16'h0001, 1'b0);
        req = 4'b0100; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL carry_gnt got %b want 0100", gnt); end
        step(); req = 4'b0000;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || gnt !== 4'b0000) begin errors++;
            $display("FAIL carry_c1 got valid=%b gnt=%b want 0 0000", out_valid, gnt); end
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL carry_valid got %b want 1", out_valid); end
        checks++; if (out_Sum !== 16'h0000 || out_Cout !== 1'b1 || out_ovf !== 1'b0 || out_id !== 2'd2) begin errors++;
            $display("FAIL carry_out got sum=%h cout=%b ovf=%b id=%0d want 0000 1 0 2", out_Sum, out_Cout, out_ovf, out_id); end
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL carry_drop got %b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        set_op(0, 16'h7FFF, 16'h0001, 1'b1);
        req = 4'b0001; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL ovf_gnt got %b want 0001", gnt); end
        step(); req = 4'b0000;
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_Sum !== 16'h8001 || out_Cout !== 1'b0 || out_ovf !== 1'b1 || out_id !== 2'd0) begin errors++;
            $display("FAIL ovf_out got v=%b sum=%h cout=%b ovf=%b id=%0d want 1 8001 0 1 0", out_valid, out_Sum, out_Cout, out_ovf, out_id); end
        step();
    endtask

    task automatic test_round_robin();
        logic [17:0] e;
        int          k;
        do_reset();
        for (int i = 0; i < c_n; i++) set_op(i, 16'(16'h1111 * (i + 1)), 16'(i), 1'b0);
        req = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            k = (c / 3) % c_n;
            checks++;
            if (c % 3 == 0) begin
                if (gnt !== 4'(1 << k)) begin errors++; $display("FAIL rr_gnt c=%0d got %b want %b", c, gnt, 4'(1 << k)); end
            end else if (gnt !== 4'b0000) begin
                errors++; $display("FAIL rr_gnt_idle c=%0d got %b want 0000", c, gnt);
            end
            if (c % 3 == 2) begin
                e = ref_add(16'(16'h1111 * (k + 1)), 16'(k), 1'b0);
                checks++;
                if (out_valid !== 1'b1 || out_id !== 2'(k) || out_Sum !== e[15:0]) begin errors++;
                    $display("FAIL rr_out c=%0d got v=%b id=%0d sum=%h want 1 %0d %h", c, out_valid, out_id, out_Sum, k, e[15:0]); end
            end
            step();
        end
        req = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_op(0, 16'h1234, 16'h4321, 1'b1);
        set_op(1, 16'hAAAA, 16'h0001, 1'b0);
        req = 4'b0001; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL bp_gnt0 got %b want 0001", gnt); end
        step(); req = 4'b0011;
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || gnt !== 4'b0000 || out_Sum !== 16'h5556 || out_Cout !== 1'b0 ||
                out_ovf !== 1'b0 || out_id !== 2'd0) begin errors++;
                $display("FAIL bp_hold c=%0d got v=%b gnt=%b sum=%h cout=%b ovf=%b id=%0d want 1 0000 5556 0 0 0",
                         c, out_valid, gnt, out_Sum, out_Cout, out_ovf, out_id); end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || gnt !== 4'b0000) begin errors++;
            $display("FAIL bp_hs got v=%b gnt=%b want 1 0000", out_valid, gnt); end
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || gnt !== 4'b0010) begin errors++;
            $display("FAIL bp_next got v=%b gnt=%b want 0 0010", out_valid, gnt); end
        step(); req = '0;
    endtask

    task automatic test_reset_exec();
        do_reset();
        set_op(1, 16'h0F0F, 16'h0101, 1'b0);
        set_op(3, 16'h0003, 16'h0004, 1'b0);
        req = 4'b0010; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rexec_gnt got %b want 0010", gnt); end
        step(); req = 4'b0000;
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rexec_valid c=%0d got %b want 0", c, out_valid); end
            step();
        end
        req = 4'b1010;
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rexec_ptr got %b want 0010", gnt); end
        step(); req = '0;
    endtask

    task automatic test_random();
        logic [3:0]  pend;
        logic [15:0] ra [c_n];
        logic [15:0] rb [c_n];
        logic        rc [c_n];
        logic [17:0] e_res;
        int          e_id, ptr, vcyc, k, nops;
        logic        busy, e_valid;
        logic [3:0]  e_gnt;
        do_reset();
        pend = '0; ptr = 0; busy = 1'b0; vcyc = 0; nops = 0; e_res = '0; e_id = 0;
        for (int i = 0; i < c_n; i++) begin ra[i] = '0; rb[i] = '0; rc[i] = 1'b0; end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < c_n; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    ra[i] = 16'($urandom); rb[i] = 16'($urandom); rc[i] = 1'($urandom);
                    if ($urandom_range(0, 3) == 0) ra[i] = {ra[i][15], 15'h7FFF};
                    set_op(i, ra[i], rb[i], rc[i]);
                end
            end
            req = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e_valid = busy && (c >= vcyc);
            k = busy ? -1 : rr_pick(pend, ptr);
            e_gnt = (k >= 0) ? 4'(1 << k) : 4'b0000;
            checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rand_gnt c=%0d got %b want %b", c, gnt, e_gnt); end
            checks++; if (out_valid !== e_valid) begin errors++; $display("FAIL rand_valid c=%0d got %b want %b", c, out_valid, e_valid); end
            if (e_valid) begin
                checks++;
                if (out_Sum !== e_res[15:0] || out_Cout !== e_res[16] || out_ovf !== e_res[17] || out_id !== 2'(e_id)) begin
                    errors++;
                    $display("FAIL rand_out c=%0d got sum=%h cout=%b ovf=%b id=%0d want %h %b %b %0d",
                             c, out_Sum, out_Cout, out_ovf, out_id, e_res[15:0], e_res[16], e_res[17], e_id);
                end
                if (out_ready) busy = 1'b0;
            end
            if (k >= 0) begin
                busy  = 1'b1;
                vcyc  = c + 2;
                e_res = ref_add(ra[k], rb[k], rc[k]);
                e_id  = k;
                ptr   = (k + 1) % c_n;
                pend[k] = 1'b0;
                nops++;
            end
            step();
        end
        checks++; if (nops < 60) begin errors++; $display("FAIL rand_ops got %0d want >=60", nops); end
        req = '0;
    endtask

    initial begin
        rst = 1'b1; req = '0; out_ready = 1'b0;
        req_A = '0; req_B = '0; req_Cin = '0;
        test_reset();
        test_single_carry();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
